apb_slave_regfile: RTL
======================

Name: apb_slave_regfile

Overview:
APB completer (slave) that terminates APB transfers issued by the bridge's APB master FSM. It holds a bank of NUM_REGS 32-bit read/write registers. Access-phase wait states are programmable. Misaligned and out-of-range accesses get an error response. Register contents and a per-write strobe are exported to downstream logic.

Parameters:
NUM_REGS, 8, number of 32-bit registers (2..256)
WAIT_STATES, 1, PREADY-low cycles inserted in every access phase (0..15)
BASE_ADDR, 32'h0000_1000, byte address of register 0 (word aligned)

Ports:
pclk  input  1  APB clock, all logic on rising edge
preset  input  1  asynchronous, active-high reset
PSEL  input  1  completer select
PENABLE  input  1  access phase indicator
PWRITE  input  1  1=write, 0=read
PADDR  input  32  byte address
PWDATA  input  32  write data
PRDATA  output  32  read data
PREADY  output  1  transfer completion
PSLVERR  output  1  error response, valid only with PREADY
reg_q  output  NUM_REGS*32  all register values; reg i at bits [32*i+31:32*i]
wr_pulse  output  1  one-cycle pulse on each committed write
wr_idx  output  8  index of the register written, valid with wr_pulse

Behaviour:
- Reset: one clock, asynchronous, active-high. preset clears all registers to 0, the FSM to IDLE, the wait counter to 0, and wr_pulse/wr_idx to 0. While in reset: PREADY=0, PSLVERR=0, PRDATA=0.
- Decode (combinational): offset = PADDR - BASE_ADDR, 32-bit unsigned. idx = offset[31:2].
  - err=1 if PADDR[1:0]!=0, if PADDR<BASE_ADDR, or if idx>=NUM_REGS.
- FSM states: IDLE, ACCESS.
  - IDLE: PREADY=0. If PSEL & !PENABLE (setup phase): load cnt=WAIT_STATES and go to ACCESS. Otherwise stay.
  - ACCESS, with PSEL & PENABLE:
    - cnt!=0: PREADY=0, cnt decrements.
    - cnt==0: PREADY=1 (combinational from state and cnt), go to IDLE at the next edge.
  - ACCESS with PSEL=0 (master abort): return to IDLE with no commit and no response.
  - ACCESS with PSEL=1, PENABLE=0 (new setup, protocol violation): reload cnt and stay in ACCESS. The old transfer is dropped.
- Latency: the access phase lasts exactly WAIT_STATES+1 cycles. With WAIT_STATES=0, PREADY is high in the first access cycle.
- Back-to-back: the completer is in IDLE on the cycle after completion, so the master's next setup is accepted with no bubble.
- Write commit: at the rising edge where PSEL & PENABLE & PREADY & PWRITE & !err.
  - reg[idx] <= PWDATA.
  - wr_pulse=1 and wr_idx=idx in the following cycle only.
  - Errored writes modify nothing and produce no wr_pulse.
- Read: PRDATA = reg[idx] when PREADY & !PWRITE & !err, else 0. Data is sampled combinationally from the current register contents.
- PSLVERR = PREADY & err, for both reads and writes. Errored transfers still take the full WAIT_STATES.
- reg_q is registered and reflects a write starting the cycle after commit, aligned with wr_pulse.
- Reset asserted mid-transfer: the FSM goes to IDLE immediately and PREADY drops asynchronously. No write is committed.

Test Plan:
1. Reset (WAIT_STATES=1): assert preset for 3 cycles with PSEL=1 -> PREADY=0, PSLVERR=0, PRDATA=0, reg_q all zero, wr_pulse=0.
2. Write then read: write 0xDEADBEEF to 0x1008, then read 0x1008 -> the write access phase is 2 cycles (PREADY low, then high); wr_pulse=1 with wr_idx=2 for one cycle; reg_q[95:64]=0xDEADBEEF; the read returns PRDATA=0xDEADBEEF with PREADY=1, PSLVERR=0.
3. Errors:
   - Write 0x1234 to 0x1020 (idx 8 >= NUM_REGS) -> PSLVERR=1 with PREADY, no wr_pulse, all registers unchanged.
   - Read 0x1002 (misaligned) -> PSLVERR=1, PRDATA=0.
   - Read 0x0FFC (below base) -> PSLVERR=1.
4. Wait-state sweep: WAIT_STATES=0, 1 and 3 -> PREADY first high in access cycle 1, 2 and 4 respectively; 10 back-to-back writes to idx 0..7 all commit with no lost transfers.
5. Abort: setup plus one access cycle to 0x1004 with WAIT_STATES=3, then PSEL=0 -> FSM returns to IDLE, reg[1] unchanged, no wr_pulse; a following normal write to 0x1004 succeeds.
6. Reset mid-access: assert preset during the wait of a write of 0x55AA55AA to 0x1000 -> PREADY drops in the same cycle and reg[0] stays 0 after release.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB completer holding a bank of 32-bit read/write registers
module apb_slave_regfile #(
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
    input  logic                   pclk,
    input  logic                   preset,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [31:0]            PADDR,
    input  logic [31:0]            PWDATA,
    output logic [31:0]            PRDATA,
    output logic                   PREADY,
    output logic                   PSLVERR,
    output logic [NUM_REGS*32-1:0] reg_q,
    output logic                   wr_pulse,
    output logic [7:0]             wr_idx
);

    localparam int          IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES);
    localparam logic [31:0] SPAN    = 32'(NUM_REGS) * 32'd4;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         cnt;
    logic [3:0]         cnt_nxt;
    logic [31:0]        offset;
    logic [IDX_W-1:0]   idx;
    logic               err;
    logic               commit;
    logic [31:0]        regs [NUM_REGS];

    // Wrap-around of the subtraction is caught by the explicit below-base test.
    always_comb begin
        offset = PADDR - BASE_ADDR;
        idx    = offset[IDX_W+1:2];
        err    = (PADDR[1:0] != 2'b00) || (PADDR < BASE_ADDR) || (offset >= SPAN);
    end

    assign PREADY  = (state == ACCESS) && PSEL && PENABLE && (cnt == 4'd0);
    assign PSLVERR = PREADY && err;
    assign PRDATA  = (PREADY && !PWRITE && !err) ? regs[idx] : 32'd0;
    assign commit  = PREADY && PWRITE && !err;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = WS_LOAD;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (!PENABLE) begin
                    // A fresh setup while busy restarts the access and drops the old one.
                    cnt_nxt = WS_LOAD;
                end else if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 32'd0;
            end
            wr_pulse <= 1'b0;
            wr_idx   <= 8'd0;
        end else begin
            wr_pulse <= commit;
            if (commit) begin
                regs[idx] <= PWDATA;
                wr_idx    <= 8'(idx);
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
        assign reg_q[32*g +: 32] = regs[g];
    end

endmodule
